// File: rtl/imem_axi_responder_pkg.sv
// Shared definitions for the instruction-memory AXI4-Lite read responder.
// The response codes are also used by the icache refill logic.
package imem_axi_responder_pkg;

    localparam int unsigned LFSR_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_W'(1) : seed;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances every cycle out of reset.
// Reusable as a cheap pseudo-random source for latency injection.
module lfsr8
    import imem_axi_responder_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] q;
    logic              feedback;

    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];
    assign out      = q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= lfsr_seed_fix(seed);
        end else begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/imem_axi_responder.sv
// AXI4-Lite read-only responder for the instruction fetch path, backed by a preloadable
// word memory, with fixed or pseudo-random response latency.
module imem_axi_responder
    import imem_axi_responder_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 1024,
    parameter logic [WIDTH-1:0] BASE    = 32'h3000_0000,
    parameter int unsigned      MIN_LAT = 1,
    parameter bit               RAND_EN = 1'b1,
    parameter logic [7:0]       SEED    = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arvalid_i,
    input  logic [WIDTH-1:0]         araddr_i,
    output logic                     arready_o,
    output logic                     rvalid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [1:0]               rresp_o,
    input  logic                     rready_i,
    input  logic                     load_en_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [WIDTH-1:0]         load_data_i
);

    localparam int unsigned    IDX_W = $clog2(DEPTH);
    localparam int unsigned    CNT_W = 5;
    localparam logic [WIDTH-1:0] SPAN = WIDTH'(4 * DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             rvalid_next;
    logic [WIDTH-1:0] rdata_next;
    logic [1:0]       rresp_next;

    logic [LFSR_W-1:0] lfsr;
    logic [5:0]        lfsr_unused;
    logic [1:0]        extra;
    logic [CNT_W-1:0]  lat_load;
    logic [WIDTH-1:0]  offset;
    logic [IDX_W-1:0]  idx;
    logic              ar_hs;

    lfsr8 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (SEED),
        .out   (lfsr)
    );

    assign lfsr_unused = lfsr[7:2];
    assign extra       = RAND_EN ? lfsr[1:0] : 2'b00;
    assign lat_load    = CNT_W'(MIN_LAT - 1) + CNT_W'(extra);

    // Wrapping subtraction: addresses below BASE land far above SPAN and decode as DECERR.
    assign offset    = araddr_i - BASE;
    assign idx       = offset[IDX_W+1:2];
    assign arready_o = (state == ST_IDLE);
    assign ar_hs     = arvalid_i && arready_o;

    // Next-state and response capture; the memory word is sampled only at the AR handshake.
    always_comb begin
        state_next  = state;
        count_next  = count;
        rvalid_next = rvalid_o;
        rdata_next  = rdata_o;
        rresp_next  = rresp_o;
        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next = ST_WAIT;
                    count_next = lat_load;
                    if (araddr_i[1:0] != 2'b00) begin
                        rresp_next = RESP_SLVERR;
                        rdata_next = '0;
                    end else if (offset >= SPAN) begin
                        rresp_next = RESP_DECERR;
                        rdata_next = '0;
                    end else begin
                        rresp_next = RESP_OKAY;
                        rdata_next = mem[idx];
                    end
                end
            end
            ST_WAIT: begin
                if (count == '0) begin
                    state_next  = ST_RESP;
                    rvalid_next = 1'b1;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rready_i) begin
                    state_next  = ST_IDLE;
                    rvalid_next = 1'b0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                rvalid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rresp_o  <= RESP_OKAY;
        end else begin
            state    <= state_next;
            count    <= count_next;
            rvalid_o <= rvalid_next;
            rdata_o  <= rdata_next;
            rresp_o  <= rresp_next;
        end
    end

    // Preload port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

endmodule

// File: tb/tb_imem_axi_responder.sv
// Directed bench for imem_axi_responder: three instances cover fixed latency 1, fixed latency 3
// and pseudo-random latency (MIN_LAT=2) with a shared clock and reset.
module tb_imem_axi_responder;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid   [3];
    logic [31:0] araddr    [3];
    logic        arready   [3];
    logic        rvalid    [3];
    logic [31:0] rdata     [3];
    logic [1:0]  rresp     [3];
    logic        rready    [3];
    logic        load_en   [3];
    logic [9:0]  load_addr [3];
    logic [31:0] load_data [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] lfsr_m;

    always #5 clk = ~clk;

    // Reference LFSR: same seed, taps x^8+x^6+x^5+x^4+1, advancing every cycle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    imem_axi_responder #(.WIDTH(32), .DEPTH(1024), .BASE(BASE), .MIN_LAT(1), .RAND_EN(1'b0), .SEED(8'hA5)) u_a (
        .clock(clk), .reset(rst), .arvalid_i(arvalid[0]), .araddr_i(araddr[0]), .arready_o(arready[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rready_i(rready[0]),
        .load_en_i(load_en[0]), .load_addr_i(load_addr[0]), .load_data_i(load_data[0]));

    imem_axi_responder #(.WIDTH(32), .DEPTH(1024), .BASE(BASE), .MIN_LAT(3), .RAND_EN(1'b0), .SEED(8'hA5)) u_b (
        .clock(clk), .reset(rst), .arvalid_i(arvalid[1]), .araddr_i(araddr[1]), .arready_o(arready[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rready_i(rready[1]),
        .load_en_i(load_en[1]), .load_addr_i(load_addr[1]), .load_data_i(load_data[1]));

    imem_axi_responder #(.WIDTH(32), .DEPTH(1024), .BASE(BASE), .MIN_LAT(2), .RAND_EN(1'b1), .SEED(8'hA5)) u_c (
        .clock(clk), .reset(rst), .arvalid_i(arvalid[2]), .araddr_i(araddr[2]), .arready_o(arready[2]),
        .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .rresp_o(rresp[2]), .rready_i(rready[2]),
        .load_en_i(load_en[2]), .load_addr_i(load_addr[2]), .load_data_i(load_data[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input int idx, input logic [31:0] data);
        load_en[k]   = 1'b1;
        load_addr[k] = 10'(idx);
        load_data[k] = data;
        step();
        load_en[k] = 1'b0;
    endtask

    // One read: handshake, measure latency, hold rready low for 'hold' cycles, then accept.
    task automatic read_check(input int k, input logic [31:0] addr, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input int exp_lat, input int hold,
                              input string tag);
        int lat;
        araddr[k]  = addr;
        arvalid[k] = 1'b1;
        rready[k]  = 1'b0;
        chk({tag, " arready_idle"}, 32'(arready[k]), 32'd1);
        step();
        arvalid[k] = 1'b0;
        load_en[k] = 1'b0;
        lat = 0;
        while (!rvalid[k] && lat < 40) begin
            chk({tag, " arready_wait"}, 32'(arready[k]), 32'd0);
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rdata"}, rdata[k], exp_data);
        chk({tag, " rresp"}, 32'(rresp[k]), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " rvalid_hold"}, 32'(rvalid[k]), 32'd1);
            chk({tag, " rdata_hold"}, rdata[k], exp_data);
            chk({tag, " arready_hold"}, 32'(arready[k]), 32'd0);
        end
        rready[k] = 1'b1;
        step();
        rready[k] = 1'b0;
        chk({tag, " rvalid_done"}, 32'(rvalid[k]), 32'd0);
        chk({tag, " arready_done"}, 32'(arready[k]), 32'd1);
    endtask

    initial begin
        int sent;
        int beats;
        int cyc;
        int extra_beats;
        int hs_cyc [8];
        int elat   [8];

        for (int k = 0; k < 3; k++) begin
            arvalid[k]   = 1'b0;
            araddr[k]    = '0;
            rready[k]    = 1'b0;
            load_en[k]   = 1'b0;
            load_addr[k] = '0;
            load_data[k] = '0;
        end
        rst = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("reset arready", 32'(arready[k]), 32'd1);
            chk("reset rvalid", 32'(rvalid[k]), 32'd0);
            chk("reset rdata", rdata[k], 32'd0);
            chk("reset rresp", 32'(rresp[k]), 32'd0);
        end
        rst = 1'b0;

        load(0, 0, 32'hDEAD_BEEF);
        load(0, 5, 32'h0000_0055);
        load(0, 1023, 32'hCAFE_F00D);
        load(1, 2, 32'h0B0B_0B0B);
        for (int i = 0; i < 8; i++) load(2, 10 + i, 32'h1000_0000 + 32'(i));

        // Fixed latency 1: data path and address decoding boundaries.
        read_check(0, BASE, 32'hDEAD_BEEF, 2'b00, 1, 0, "a_base");
        read_check(0, BASE + 32'h2, 32'h0, 2'b10, 1, 0, "a_misalign");
        read_check(0, BASE + 32'h1000, 32'h0, 2'b11, 1, 0, "a_above");
        read_check(0, BASE - 32'h4, 32'h0, 2'b11, 1, 0, "a_below");
        read_check(0, BASE + 32'hFFC, 32'hCAFE_F00D, 2'b00, 1, 2, "a_last");

        // Preload on the handshake edge returns the old word; the next read sees the new one.
        load_en[0]   = 1'b1;
        load_addr[0] = 10'd5;
        load_data[0] = 32'h0000_0001;
        read_check(0, BASE + 32'h14, 32'h0000_0055, 2'b00, 1, 0, "a_same_edge");
        read_check(0, BASE + 32'h14, 32'h0000_0001, 2'b00, 1, 0, "a_after_load");

        // Fixed latency 3 with a 4-cycle rready stall.
        read_check(1, BASE + 32'h8, 32'h0B0B_0B0B, 2'b00, 3, 4, "b_lat3_hold");

        // Random latency: MIN_LAT plus the low two LFSR bits at the handshake.
        read_check(2, BASE + 32'h28, 32'h1000_0000, 2'b00, 2 + int'(lfsr_m[1:0]), 1, "c_rand");

        // Back-to-back: arvalid held high, rready high, 8 requests.
        rready[2] = 1'b1;
        sent  = 0;
        beats = 0;
        cyc   = 0;
        while (beats < 8 && cyc < 300) begin
            arvalid[2] = (sent < 8);
            if (rvalid[2]) begin
                if (beats < sent) begin
                    chk("c_b2b rdata", rdata[2], 32'h1000_0000 + 32'(beats));
                    chk("c_b2b latency", 32'(cyc - hs_cyc[beats] - 1), 32'(elat[beats]));
                end else begin
                    chk("c_b2b beat_without_request", 32'(beats), 32'(sent - 1));
                end
                beats++;
            end
            if (arready[2] && sent < 8) begin
                araddr[2]    = BASE + 32'(4 * (10 + sent));
                hs_cyc[sent] = cyc;
                elat[sent]   = 2 + int'(lfsr_m[1:0]);
                sent++;
            end
            step();
            cyc++;
        end
        arvalid[2] = 1'b0;
        chk("c_b2b beats", 32'(beats), 32'd8);
        extra_beats = 0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid[2]) extra_beats++;
            step();
        end
        chk("c_b2b extra_beats", 32'(extra_beats), 32'd0);
        rready[2] = 1'b0;

        // Reset while waiting out the latency.
        araddr[1]  = BASE + 32'h8;
        arvalid[1] = 1'b1;
        step();
        arvalid[1] = 1'b0;
        step();
        chk("b_wait arready_before_reset", 32'(arready[1]), 32'd0);
        rst = 1'b1;
        #1;
        chk("b_rst_wait rvalid", 32'(rvalid[1]), 32'd0);
        chk("b_rst_wait arready", 32'(arready[1]), 32'd1);
        step();
        rst = 1'b0;

        // Reset while presenting a response: rvalid must drop without a clock edge.
        arvalid[1] = 1'b1;
        step();
        arvalid[1] = 1'b0;
        for (int i = 0; i < 10 && !rvalid[1]; i++) step();
        chk("b_resp reached", 32'(rvalid[1]), 32'd1);
        rst = 1'b1;
        #1;
        chk("b_rst_resp rvalid", 32'(rvalid[1]), 32'd0);
        chk("b_rst_resp arready", 32'(arready[1]), 32'd1);
        chk("b_rst_resp rdata", rdata[1], 32'd0);
        step();
        rst = 1'b0;

        read_check(1, BASE + 32'h8, 32'h0B0B_0B0B, 2'b00, 3, 0, "b_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
